// File: rtl/ucode_sequencer.sv
// Microcode sequencer: steps the control-ROM address through a decoded instruction's micro-ops.
// REP looping (REP_CHK bubble, ecx_zero/rep_term exit) is built only when UCODE_REP_EN is defined.
module ucode_sequencer #(
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rom_addr,
   input  logic [CNT_W-1:0]  in_uop_cnt,
   input  logic              in_rep,
   input  logic              ecx_zero,
   input  logic              rep_term,
   input  logic              stall,
   input  logic              flush,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              uop_valid,
   output logic              uop_first,
   output logic              uop_last,
   output logic              instr_done
);
   localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);
   localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, REP_CHK} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, r_idx, w_idx_nxt, w_acc_cnt;
   logic              r_valid, w_valid_nxt, r_first, w_first_nxt;
   logic              r_last, w_last_nxt, r_done, w_done_nxt;
   logic              w_last_uop, w_consume, w_cur_rep, w_acc_rep, w_acc_skip, w_accept;

`ifdef UCODE_REP_EN
   logic [ADDR_W-1:0] r_base, w_base_nxt;
   logic              r_rep, w_rep_nxt;
   assign w_cur_rep  = r_rep;
   assign w_acc_rep  = in_rep;
   assign w_acc_skip = in_rep & ecx_zero;
`else
   logic w_unused;
   assign w_unused   = &{1'b0, in_rep, ecx_zero, rep_term};
   assign w_cur_rep  = 1'b0;
   assign w_acc_rep  = 1'b0;
   assign w_acc_skip = 1'b0;
`endif

   assign w_acc_cnt  = (in_uop_cnt == '0) ? C_ONE : in_uop_cnt;
   assign w_last_uop = (r_idx == r_cnt - C_ONE);
   assign w_consume  = (r_state == ISSUE) && !stall;
   // A retiring non-REP instruction frees the slot, so the next one can be taken without a bubble.
   assign in_ready   = !flush && ((r_state == IDLE) || (w_consume && w_last_uop && !w_cur_rep));
   assign w_accept   = in_valid && in_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_rom_addr_nxt = r_rom_addr;
      w_cnt_nxt      = r_cnt;
      w_idx_nxt      = r_idx;
      w_valid_nxt    = r_valid;
      w_first_nxt    = r_first;
      w_last_nxt     = r_last;
      w_done_nxt     = 1'b0;
`ifdef UCODE_REP_EN
      w_base_nxt     = r_base;
      w_rep_nxt      = r_rep;
`endif
      if (flush) begin
         w_state_nxt = IDLE;
         w_valid_nxt = 1'b0;
         w_first_nxt = 1'b0;
         w_last_nxt  = 1'b0;
      end else begin
         case (r_state)
            ISSUE: if (!stall) begin
               w_first_nxt = 1'b0;
               if (!w_last_uop) begin
                  w_idx_nxt      = r_idx + C_ONE;
                  w_rom_addr_nxt = r_rom_addr + A_ONE;
                  w_last_nxt     = ((r_idx + C_ONE) == (r_cnt - C_ONE)) && !w_cur_rep;
               end else begin
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
                  w_state_nxt = w_cur_rep ? REP_CHK : IDLE;
                  w_done_nxt  = !w_cur_rep;
               end
            end
`ifdef UCODE_REP_EN
            REP_CHK: if (ecx_zero || rep_term) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt    = ISSUE;
               w_idx_nxt      = '0;
               w_rom_addr_nxt = r_base;
               w_valid_nxt    = 1'b1;
               w_first_nxt    = 1'b0;
               w_last_nxt     = 1'b0;
            end
`endif
            default: ;
         endcase
         // Accept overrides the retire path above; a pending instr_done from it is kept.
         if (w_accept) begin
            w_cnt_nxt = w_acc_cnt;
            w_idx_nxt = '0;
`ifdef UCODE_REP_EN
            w_base_nxt = in_rom_addr;
            w_rep_nxt  = in_rep;
`endif
            if (w_acc_skip) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
               w_valid_nxt = 1'b0;
               w_first_nxt = 1'b0;
               w_last_nxt  = 1'b0;
            end else begin
               w_state_nxt    = ISSUE;
               w_rom_addr_nxt = in_rom_addr;
               w_valid_nxt    = 1'b1;
               w_first_nxt    = 1'b1;
               w_last_nxt     = (w_acc_cnt == C_ONE) && !w_acc_rep;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_rom_addr <= '0;
         r_cnt      <= C_ONE;
         r_idx      <= '0;
         r_valid    <= 1'b0;
         r_first    <= 1'b0;
         r_last     <= 1'b0;
         r_done     <= 1'b0;
`ifdef UCODE_REP_EN
         r_base     <= '0;
         r_rep      <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_rom_addr <= w_rom_addr_nxt;
         r_cnt      <= w_cnt_nxt;
         r_idx      <= w_idx_nxt;
         r_valid    <= w_valid_nxt;
         r_first    <= w_first_nxt;
         r_last     <= w_last_nxt;
         r_done     <= w_done_nxt;
`ifdef UCODE_REP_EN
         r_base     <= w_base_nxt;
         r_rep      <= w_rep_nxt;
`endif
      end
   end

   assign rom_addr   = r_rom_addr;
   assign uop_valid  = r_valid;
   assign uop_first  = r_first;
   assign uop_last   = r_last;
   assign instr_done = r_done;
endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: expected micro-op streams are built as queues from the
// instruction fields, then replayed cycle by cycle against the DUT under random stalls.
module tb_ucode_sequencer;
`ifdef UCODE_REP_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic       clk, rst_n, in_valid, in_ready, in_rep, ecx_zero, rep_term, stall, flush;
   logic [7:0] in_rom_addr, rom_addr;
   logic [2:0] in_uop_cnt;
   logic       uop_valid, uop_first, uop_last, instr_done;

   typedef struct packed { logic v; logic [7:0] a; logic f; logic l; } uop_t;

   int n_chk  = 0;
   int n_fail = 0;

   ucode_sequencer #(.ADDR_W(8), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rom_addr(in_rom_addr), .in_uop_cnt(in_uop_cnt), .in_rep(in_rep),
      .ecx_zero(ecx_zero), .rep_term(rep_term), .stall(stall), .flush(flush),
      .rom_addr(rom_addr), .uop_valid(uop_valid), .uop_first(uop_first),
      .uop_last(uop_last), .instr_done(instr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic idle_inputs();
      in_valid    = 1'b0;
      in_rom_addr = 8'($urandom);
      in_uop_cnt  = 3'($urandom);
      in_rep      = 1'($urandom);
      ecx_zero    = 1'($urandom);
      rep_term    = 1'($urandom);
      stall       = 1'($urandom);
      flush       = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_chk++;
      if ({uop_valid, uop_first, uop_last, instr_done, in_ready} !== 5'b00001 || rom_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL reset: v/f/l/done/rdy=%b addr=%h, want 00001 addr=00",
                  {uop_valid, uop_first, uop_last, instr_done, in_ready}, rom_addr);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         @(negedge clk);
         n_chk++;
         if ({uop_valid, instr_done, in_ready} !== 3'b001 || rom_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL idle%0d: v/done/rdy=%b addr=%h, want 001 addr=00", i,
                     {uop_valid, instr_done, in_ready}, rom_addr);
         end
         @(posedge clk); #1;
      end
   endtask

   // Drives one instruction from IDLE and checks the whole stream plus the retire pulse.
   // iters = REP iterations (0 = ecx_zero at accept); hold_idx/hold_n give a directed stall.
   task automatic run_instr(input logic [7:0] a, input logic [2:0] c, input bit rep, input int iters,
                            input int stall_pct, input int hold_idx, input int hold_n, input string nm);
      uop_t q[$];
      uop_t e;
      int   eff, nit, idx, bub, held, guard;
      bit   looping;
      logic [4:0] want, got;
      eff     = (c == 3'd0) ? 1 : int'(c);
      looping = rep && REP_EN;
      nit     = looping ? iters : 1;
      for (int it = 0; it < nit; it++) begin
         for (int j = 0; j < eff; j++)
            q.push_back('{1'b1, 8'(a + 8'(j)), (it == 0 && j == 0), (!looping && j == eff - 1)});
         if (looping) q.push_back('{1'b0, 8'h00, 1'b0, 1'b0});
      end

      idle_inputs();
      in_valid = 1'b1; in_rom_addr = a; in_uop_cnt = c; in_rep = rep;
      if (looping) ecx_zero = (iters == 0);
      @(negedge clk);
      n_chk++;
      if ({uop_valid, instr_done, in_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL %s accept: v/done/rdy=%b, want 001", nm, {uop_valid, instr_done, in_ready});
      end
      @(posedge clk); #1;

      idx = 0; bub = 0; held = 0; guard = 0;
      while (idx < q.size() && guard < 500) begin
         e = q[idx];
         idle_inputs();
         if (hold_idx >= 0) begin
            stall = (idx == hold_idx) && (held < hold_n);
            if (stall) held++;
         end else begin
            stall = ($urandom_range(0, 99) < stall_pct);
         end
         if (!e.v) begin
            ecx_zero = 1'b0; rep_term = 1'b0;
            if (bub == nit - 1) begin
               if ($urandom_range(0, 1) == 1) ecx_zero = 1'b1;
               else rep_term = 1'b1;
            end
            bub++;
         end
         @(negedge clk);
         want = {e.v, e.f, e.l, 1'b0, e.v & e.l & ~stall};
         got  = {uop_valid, uop_first, uop_last, instr_done, in_ready};
         n_chk++;
         if (got !== want || (e.v && rom_addr !== e.a)) begin
            n_fail++;
            $display("FAIL %s step%0d: v/f/l/done/rdy=%b addr=%h, want %b addr=%h",
                     nm, idx, got, rom_addr, want, e.a);
         end
         @(posedge clk); #1;
         if (!e.v || !stall) idx++;
         guard++;
      end
      if (guard >= 500) begin
         n_fail++;
         $display("FAIL %s timeout: stream stuck at step %0d of %0d", nm, idx, q.size());
      end

      idle_inputs();
      @(negedge clk);
      n_chk++;
      if ({uop_valid, instr_done, in_ready} !== 3'b011) begin
         n_fail++;
         $display("FAIL %s retire: v/done/rdy=%b, want 011", nm, {uop_valid, instr_done, in_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b, wa;
      logic [4:0] want, got;
      int k1, k2, jj;
      a  = 8'($urandom); b = 8'($urandom);
      k1 = $urandom_range(1, 7); k2 = $urandom_range(1, 7);
      idle_inputs();
      stall = 1'b0; in_valid = 1'b1; in_rom_addr = a; in_uop_cnt = 3'(k1); in_rep = 1'b0;
      @(posedge clk); #1;
      for (int j = 0; j < k1 + k2 + 1; j++) begin
         idle_inputs();
         stall = 1'b0;
         if (j == k1 - 1) begin
            in_valid = 1'b1; in_rom_addr = b; in_uop_cnt = 3'(k2); in_rep = 1'b0;
         end
         if (j < k1) begin
            want = {1'b1, j == 0, j == k1 - 1, 1'b0, j == k1 - 1};
            wa   = 8'(a + 8'(j));
         end else if (j < k1 + k2) begin
            jj   = j - k1;
            want = {1'b1, jj == 0, jj == k2 - 1, jj == 0, jj == k2 - 1};
            wa   = 8'(b + 8'(jj));
         end else begin
            want = 5'b00011;
            wa   = rom_addr;
         end
         @(negedge clk);
         got = {uop_valid, uop_first, uop_last, instr_done, in_ready};
         n_chk++;
         if (got !== want || (want[4] && rom_addr !== wa)) begin
            n_fail++;
            $display("FAIL b2b cyc%0d: v/f/l/done/rdy=%b addr=%h, want %b addr=%h",
                     j, got, rom_addr, want, wa);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush();
      logic [7:0] a;
      logic [4:0] got;
      a = 8'($urandom);
      idle_inputs();
      stall = 1'b0; in_valid = 1'b1; in_rom_addr = a; in_uop_cnt = 3'd4; in_rep = 1'b0;
      @(posedge clk); #1;
      idle_inputs(); stall = 1'b0;
      @(posedge clk); #1;
      idle_inputs(); stall = 1'b0; flush = 1'b1; in_valid = 1'b1; in_rep = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({uop_valid, in_ready} !== 2'b10 || rom_addr !== 8'(a + 8'd1)) begin
         n_fail++;
         $display("FAIL flush cycle: v/rdy=%b addr=%h, want 10 addr=%h",
                  {uop_valid, in_ready}, rom_addr, 8'(a + 8'd1));
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         idle_inputs();
         if (i == 1) begin flush = 1'b1; in_valid = 1'b1; end
         @(negedge clk);
         got = {uop_valid, uop_first, uop_last, instr_done, in_ready};
         n_chk++;
         if (got !== ((i == 1) ? 5'b00000 : 5'b00001)) begin
            n_fail++;
            $display("FAIL flush after%0d: v/f/l/done/rdy=%b, want %b", i, got,
                     (i == 1) ? 5'b00000 : 5'b00001);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      idle_inputs();
      stall = 1'b0; in_valid = 1'b1; in_rom_addr = 8'h20; in_uop_cnt = 3'd5; in_rep = 1'b0;
      @(posedge clk); #1;
      idle_inputs(); stall = 1'b0;
      @(posedge clk); #1;
      idle_inputs(); stall = 1'b0;
      @(negedge clk);
      n_chk++;
      if (uop_valid !== 1'b1 || rom_addr !== 8'h21) begin
         n_fail++;
         $display("FAIL areset pre: v=%b addr=%h, want 1 addr=21", uop_valid, rom_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({uop_valid, uop_first, uop_last, instr_done, in_ready} !== 5'b00001 || rom_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL areset mid: v/f/l/done/rdy=%b addr=%h, want 00001 addr=00",
                  {uop_valid, uop_first, uop_last, instr_done, in_ready}, rom_addr);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      idle_inputs();
      @(negedge clk);
      n_chk++;
      if ({uop_valid, instr_done, in_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL areset post: v/done/rdy=%b, want 001", {uop_valid, instr_done, in_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++)
         run_instr(8'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 3), 30, -1, 0, "rand");
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      run_instr(8'h40, 3'd3, 1'b0, 1, 0, -1, 0, "basic");
      run_instr(8'h40, 3'd3, 1'b0, 1, 0, 1, 2, "stall");
      run_instr(8'h80, 3'd2, 1'b1, 2, 0, -1, 0, "rep2");
      run_instr(8'h90, 3'd3, 1'b1, 0, 0, -1, 0, "rep_ecx0");
      run_instr(8'hFF, 3'd2, 1'b0, 1, 0, -1, 0, "wrap");
      run_instr(8'h10, 3'd0, 1'b0, 1, 0, -1, 0, "cnt0");
      test_flush();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
